// File: rtl/lcd_capture.sv
// Display-stream sink: recovers pixel coordinates from the sync levels, packs
// 2-bit shades four per byte and fills a double-buffered 160x144 framebuffer.
module lcd_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  output logic        fb_write,
  output logic        fb_bank,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        frame_done,
  output logic        display_bank,
  output logic        sync_err
);

  localparam logic [7:0] XMAX = 8'd160;
  localparam logic [7:0] YMAX = 8'd144;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    CAPTURE,
    VBLANK
  } state_e;

  state_e      state_q, state_d;
  logic        vsync_q, hsync_q;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [12:0] addr_q, addr_d;
  logic [5:0]  acc_q, acc_d;
  logic [1:0]  ph_q, ph_d;
  logic        wr_q, wr_d;
  logic [12:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        bank_q, bank_d;
  logic        disp_q, disp_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic vs_rise, vs_fall, hs_rise;
  logic abort;

  assign vs_rise = lcd_vsync & ~vsync_q;
  assign vs_fall = ~lcd_vsync & vsync_q;
  assign hs_rise = lcd_hsync & ~hsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      ph_q    <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      bank_q  <= 1'b0;
      disp_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= lcd_vsync;
      hsync_q <= lcd_hsync;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      bank_q  <= bank_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    ph_d    = ph_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    bank_d  = bank_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      WAIT_SYNC, VBLANK: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          acc_d   = '0;
          ph_d    = '0;
        end
      end
      CAPTURE: begin
        if (lcd_pixel) begin
          if (y_q == YMAX || x_q == XMAX) begin
            err_d   = 1'b1;
            state_d = WAIT_SYNC;
            abort   = 1'b1;
          end else begin
            acc_d = {acc_q[3:0], lcd_color};
            x_d   = x_q + 8'd1;
            ph_d  = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
              wr_d    = 1'b1;
              wdata_d = {acc_q, lcd_color};
              waddr_d = addr_q;
              addr_d  = addr_q + 13'd1;
            end
          end
        end
        // line/frame checks see the counters after this cycle's pixel
        if (!abort && hs_rise) begin
          if (x_d == XMAX) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_SYNC;
            abort   = 1'b1;
          end
        end
        if (!abort && vs_rise) begin
          state_d = VBLANK;
          if (y_d == YMAX && x_d == 8'd0) begin
            done_d = 1'b1;
            bank_d = ~bank_q;
            disp_d = bank_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  assign fb_write     = wr_q;
  assign fb_bank      = bank_q;
  assign fb_addr      = waddr_q;
  assign fb_data      = wdata_q;
  assign frame_done   = done_q;
  assign display_bank = disp_q;
  assign sync_err     = err_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: good frames, short/long lines,
// startup noise and reset mid-frame.
module tb_lcd_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic        px = 1'b0;
  logic [1:0]  col = 2'd0;
  logic        fb_write, fb_bank, frame_done, display_bank, sync_err;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;

  lcd_capture dut (
    .clk          (clk),
    .rst          (rst),
    .lcd_hsync    (hs),
    .lcd_vsync    (vs),
    .lcd_pixel    (px),
    .lcd_color    (col),
    .fb_write     (fb_write),
    .fb_bank      (fb_bank),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .frame_done   (frame_done),
    .display_bank (display_bank),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: counts writes/pulses and checks write ordering per frame
  logic        clr = 1'b0;
  logic [7:0]  exp_data = 8'h1B;
  logic        exp_bank = 1'b0;
  int          wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int          addr_bad = 0, data_bad = 0, bank_bad = 0, inv_bad = 0;
  int          wr_at_done = 0;
  logic [12:0] exp_addr = '0;

  always @(negedge clk) begin
    if (clr) begin
      wr_cnt     <= 0;
      done_cnt   <= 0;
      err_cnt    <= 0;
      addr_bad   <= 0;
      data_bad   <= 0;
      bank_bad   <= 0;
      wr_at_done <= 0;
      exp_addr   <= '0;
    end else begin
      if (fb_write) begin
        wr_cnt   <= wr_cnt + 1;
        exp_addr <= exp_addr + 13'd1;
        if (fb_addr !== exp_addr) addr_bad <= addr_bad + 1;
        if (fb_data !== exp_data) data_bad <= data_bad + 1;
        if (fb_bank !== exp_bank) bank_bad <= bank_bad + 1;
      end
      if (frame_done) begin
        done_cnt   <= done_cnt + 1;
        wr_at_done <= wr_cnt;
      end
      if (sync_err) err_cnt <= err_cnt + 1;
    end
    if (!rst && display_bank !== ~fb_bank) inv_bad <= inv_bad + 1;
  end

  function automatic logic [25:0] outv();
    return {fb_write, fb_bank, fb_addr, fb_data,
            frame_done, display_bank, sync_err};
  endfunction

  localparam logic [25:0] RST_V = 26'd2;

  task automatic step(input logic h, input logic v, input logic p,
                      input logic [1:0] c);
    @(posedge clk);
    #1;
    hs  = h;
    vs  = v;
    px  = p;
    col = c;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(hs, vs, 1'b0, 2'd0);
  endtask

  task automatic clear();
    clr = 1'b1;
    hold(1);
    clr = 1'b0;
    hold(1);
  endtask

  task automatic line(input int n, input logic inv);
    logic [1:0] s;
    for (int i = 0; i < n; i++) begin
      s = i[1:0];
      if (inv) s = ~s;
      step(1'b0, 1'b0, 1'b1, s);
    end
    step(1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic lines(input int n, input logic inv);
    for (int l = 0; l < n; l++) line(160, inv);
  endtask

  task automatic vstart();
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic vend();
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    hold(3);
    chk("rst_init", 32'(outv()), 32'(RST_V));
    rst = 1'b0;
    clear();

    // startup noise before any vsync fall
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    hold(3);
    chk("start_wr", wr_cnt, 0);
    chk("start_err", err_cnt, 0);

    // partial frame of 71 lines, then reset
    clear();
    exp_data = 8'h1B;
    exp_bank = 1'b0;
    vstart();
    lines(71, 1'b0);
    hold(2);
    chk("part_wr", wr_cnt, 2840);
    chk("part_addr", addr_bad, 0);
    chk("part_data", data_bad, 0);
    rst = 1'b1;
    hold(1);
    chk("mid_rst_out", 32'(outv()), 32'(RST_V));
    rst = 1'b0;
    hold(2);
    chk("mid_rst_done", done_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);

    // frame A: bank 0, shades 0,1,2,3
    clear();
    exp_data = 8'h1B;
    exp_bank = 1'b0;
    vstart();
    lines(144, 1'b0);
    vend();
    chk("fA_done_now", 32'(frame_done), 1);
    chk("fA_banks", 32'({fb_bank, display_bank}), 32'(2'b10));
    hold(3);
    chk("fA_wr", wr_cnt, 5760);
    chk("fA_addr", addr_bad, 0);
    chk("fA_data", data_bad, 0);
    chk("fA_bank", bank_bad, 0);
    chk("fA_done", done_cnt, 1);
    chk("fA_err", err_cnt, 0);
    chk("fA_last_wr", wr_at_done, 5760);

    // frame B: bank 1, shades 3,2,1,0
    clear();
    exp_data = 8'hE4;
    exp_bank = 1'b1;
    vstart();
    lines(144, 1'b1);
    vend();
    chk("fB_done_now", 32'(frame_done), 1);
    chk("fB_banks", 32'({fb_bank, display_bank}), 32'(2'b01));
    hold(3);
    chk("fB_wr", wr_cnt, 5760);
    chk("fB_addr", addr_bad, 0);
    chk("fB_data", data_bad, 0);
    chk("fB_bank", bank_bad, 0);
    chk("fB_done", done_cnt, 1);
    chk("fB_err", err_cnt, 0);

    // short line 5 (159 pixels)
    clear();
    exp_data = 8'h1B;
    exp_bank = 1'b0;
    vstart();
    lines(5, 1'b0);
    line(159, 1'b0);
    hold(1);
    chk("short_err_now", 32'(sync_err), 1);
    lines(3, 1'b0);
    vend();
    hold(3);
    chk("short_err", err_cnt, 1);
    chk("short_wr", wr_cnt, 239);
    chk("short_addr", addr_bad, 0);
    chk("short_done", done_cnt, 0);
    chk("short_banks", 32'({fb_bank, display_bank}), 32'(2'b01));

    // long line 0 (161 pixels)
    clear();
    vstart();
    line(161, 1'b0);
    chk("long_err_now", 32'(sync_err), 1);
    lines(2, 1'b0);
    vend();
    hold(3);
    chk("long_err", err_cnt, 1);
    chk("long_wr", wr_cnt, 40);
    chk("long_done", done_cnt, 0);
    chk("long_banks", 32'({fb_bank, display_bank}), 32'(2'b01));
    chk("bank_inv", inv_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
